// File: rtl/snoop_filter_pkg.sv
// Shared types and helpers for the snoop filter tag-array memory responder.
package snoop_filter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        DONE
    } sf_mem_state_e;

    localparam int SF_MAX_RD_LATENCY = 2;
    localparam int SF_PAR_MAX_W      = 1024;

    // Even parity; callers zero-extend, which leaves the parity unchanged.
    function automatic logic sf_par(input logic [SF_PAR_MAX_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/sf_mem_rd_pipe.sv
// Read-return shift pipe: LATENCY stages of valid plus payload, cleared by reset.
module sf_mem_rd_pipe
    import snoop_filter_pkg::*;
#(
    parameter int LATENCY = 1,
    parameter int W       = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_vld,
    input  logic [W-1:0] in_dat,
    output logic         out_vld,
    output logic [W-1:0] out_dat
);

    if (LATENCY < 1 || LATENCY > SF_MAX_RD_LATENCY) begin : g_bad_latency
        $fatal(1, "sf_mem_rd_pipe: LATENCY must be 1..%0d", SF_MAX_RD_LATENCY);
    end

    logic         vld_p [LATENCY];
    logic [W-1:0] dat_p [LATENCY];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < LATENCY; i++) begin
                vld_p[i] <= 1'b0;
                dat_p[i] <= '0;
            end
        end else begin
            vld_p[0] <= in_vld;
            dat_p[0] <= in_dat;
            for (int i = 1; i < LATENCY; i++) begin
                vld_p[i] <= vld_p[i-1];
                dat_p[i] <= dat_p[i-1];
            end
        end
    end

    assign out_vld = vld_p[LATENCY-1];
    assign out_dat = dat_p[LATENCY-1];

endmodule

// File: rtl/snoop_filter_mem_responder.sv
// Snoop filter tag-array responder: fixed-latency reads, writes, and a zeroing init sweep.
// Optional per-row parity is enabled by defining SF_MEM_PARITY_EN.
module snoop_filter_mem_responder
    import snoop_filter_pkg::*;
#(
    parameter int NSETS      = 64,
    parameter int DATA_W     = 64,
    parameter int RD_LATENCY = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     mnt_ops,
    input  logic                     cen,
    input  logic                     wen,
    input  logic [DATA_W-1:0]        data,
    input  logic [$clog2(NSETS)-1:0] set_index,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     rd_valid,
    output logic                     busy,
    output logic                     mnt_done,
    output logic                     err_busy
`ifdef SF_MEM_PARITY_EN
    ,
    input  logic                     inj_par_err,
    output logic                     rd_par_err
`endif
);

    localparam int IDX_W = $clog2(NSETS);
`ifdef SF_MEM_PARITY_EN
    localparam int ROW_W = DATA_W + 1;
`else
    localparam int ROW_W = DATA_W;
`endif
    localparam logic [IDX_W-1:0] LAST_SET = IDX_W'(NSETS - 1);

    if (NSETS < 2 || (NSETS & (NSETS - 1)) != 0) begin : g_bad_nsets
        $fatal(1, "snoop_filter_mem_responder: NSETS must be a power of 2 >= 2");
    end
    if (RD_LATENCY < 1 || RD_LATENCY > SF_MAX_RD_LATENCY) begin : g_bad_latency
        $fatal(1, "snoop_filter_mem_responder: RD_LATENCY must be 1..%0d", SF_MAX_RD_LATENCY);
    end
    if (DATA_W < 1 || DATA_W > SF_PAR_MAX_W) begin : g_bad_width
        $fatal(1, "snoop_filter_mem_responder: DATA_W out of range");
    end

    sf_mem_state_e    state, state_next;
    logic [IDX_W-1:0] sweep_ptr, sweep_ptr_next;
    logic [ROW_W-1:0] mem [NSETS];
    logic [ROW_W-1:0] row_wr;
    logic [ROW_W-1:0] row_rd;
    logic             accept, wr_en, rd_en;

    // Accesses are only honoured in IDLE; a same-cycle mnt_ops still lets them through.
    assign accept = cen && (state == IDLE);
    assign wr_en  = accept && wen;
    assign rd_en  = accept && !wen;
    assign row_rd = mem[set_index];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            sweep_ptr <= '0;
        end else begin
            state     <= state_next;
            sweep_ptr <= sweep_ptr_next;
        end
    end

    always_comb begin
        state_next     = state;
        sweep_ptr_next = sweep_ptr;
        case (state)
            IDLE: begin
                if (mnt_ops) begin
                    state_next     = SWEEP;
                    sweep_ptr_next = '0;
                end
            end
            SWEEP: begin
                if (sweep_ptr == LAST_SET) begin
                    state_next = DONE;
                end else begin
                    sweep_ptr_next = sweep_ptr + 1'b1;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy     = (state != IDLE);
    assign mnt_done = (state == DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_busy <= 1'b0;
        end else begin
            err_busy <= cen && (state != IDLE);
        end
    end

    // Writes are suppressed under reset so an aborted sweep leaves the current row intact.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state == SWEEP) begin
                mem[sweep_ptr] <= '0;
            end else if (wr_en) begin
                mem[set_index] <= row_wr;
            end
        end
    end

`ifdef SF_MEM_PARITY_EN
    logic              par_err_rd;
    logic [DATA_W:0]   pipe_out;

    assign row_wr     = {sf_par(SF_PAR_MAX_W'(data)) ^ inj_par_err, data};
    assign par_err_rd = rd_en && (sf_par(SF_PAR_MAX_W'(row_rd[DATA_W-1:0])) != row_rd[DATA_W]);

    sf_mem_rd_pipe #(
        .LATENCY (RD_LATENCY),
        .W       (DATA_W + 1)
    ) u_rd_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_vld  (rd_en),
        .in_dat  ({par_err_rd, row_rd[DATA_W-1:0]}),
        .out_vld (rd_valid),
        .out_dat (pipe_out)
    );

    assign {rd_par_err, rd_data} = pipe_out;
`else
    assign row_wr = data;

    sf_mem_rd_pipe #(
        .LATENCY (RD_LATENCY),
        .W       (DATA_W)
    ) u_rd_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_vld  (rd_en),
        .in_dat  (row_rd),
        .out_vld (rd_valid),
        .out_dat (rd_data)
    );
`endif

endmodule
